// File: rtl/key_pulse_gen.sv
// key_pulse_gen: debounces two active-low push-buttons and turns presses into
// one-cycle inc/dec requests with optional auto-repeat and a both-held lockout.
module key_pulse_gen #(
   parameter int DEBOUNCE_CYCLES      = 125000,
   parameter int REPEAT_DELAY_CYCLES  = 62500000,
   parameter int REPEAT_PERIOD_CYCLES = 12500000,
   parameter int REPEAT_EN            = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic i_key0_n,
   input  logic i_key1_n,
   output logic o_inc_pulse,
   output logic o_dec_pulse,
   output logic o_key0_level,
   output logic o_key1_level
);
   localparam int DW  = $clog2(DEBOUNCE_CYCLES) > 0 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TDW = $clog2(REPEAT_DELAY_CYCLES) > 0 ? $clog2(REPEAT_DELAY_CYCLES) : 1;
   localparam int TPW = $clog2(REPEAT_PERIOD_CYCLES) > 0 ? $clog2(REPEAT_PERIOD_CYCLES) : 1;
   localparam int TW  = TDW > TPW ? TDW : TPW;

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

   logic [1:0]    s1, s2, lvl, lev, req, pulse;
   logic [DW-1:0] cnt [2];
   logic [TW-1:0] tmr [2];
   logic [TW-1:0] tmr_nx [2];
   state_t        st [2];
   state_t        st_nx [2];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1    <= '0;
         s2    <= '0;
         lvl   <= '0;
         lev   <= '0;
         pulse <= '0;
         for (int i = 0; i < 2; i++) begin
            cnt[i] <= '0;
            tmr[i] <= '0;
            st[i]  <= IDLE;
         end
      end else begin
         s1  <= ~{i_key1_n, i_key0_n};
         s2  <= s1;
         lev <= lvl;
         // a key's pulse is dropped if the other key is held now or becomes held at this edge
         pulse <= req & ~{lvl[0], lvl[1]} & ~{lev[0], lev[1]};
         for (int i = 0; i < 2; i++) begin
            st[i]  <= st_nx[i];
            tmr[i] <= tmr_nx[i];
            if (s2[i] == lvl[i])
               cnt[i] <= '0;
            else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               lvl[i] <= ~lvl[i];
               cnt[i] <= '0;
            end else
               cnt[i] <= (&cnt[i]) ? cnt[i] : cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         st_nx[i]  = st[i];
         tmr_nx[i] = tmr[i];
         req[i]    = 1'b0;
         case (st[i])
            IDLE: if (lev[i]) begin
               st_nx[i]  = DELAY;
               tmr_nx[i] = '0;
               req[i]    = 1'b1;
            end
            DELAY: if (!lev[i]) begin
               st_nx[i]  = IDLE;
               tmr_nx[i] = '0;
            end else if (REPEAT_EN != 0) begin
               if (tmr[i] == TW'(REPEAT_DELAY_CYCLES - 1)) begin
                  st_nx[i]  = REPEAT;
                  tmr_nx[i] = '0;
                  req[i]    = 1'b1;
               end else
                  tmr_nx[i] = tmr[i] + 1'b1;
            end
            REPEAT: if (!lev[i]) begin
               st_nx[i]  = IDLE;
               tmr_nx[i] = '0;
            end else if (tmr[i] == TW'(REPEAT_PERIOD_CYCLES - 1)) begin
               tmr_nx[i] = '0;
               req[i]    = 1'b1;
            end else
               tmr_nx[i] = tmr[i] + 1'b1;
            default: begin
               st_nx[i]  = IDLE;
               tmr_nx[i] = '0;
            end
         endcase
      end
   end

   assign o_inc_pulse  = pulse[0];
   assign o_dec_pulse  = pulse[1];
   assign o_key0_level = lev[0];
   assign o_key1_level = lev[1];
endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: directed scenarios for key_pulse_gen with small timing parameters;
// edge e of a scenario is the e-th clock edge after its first key change.
module tb_key_pulse_gen;
   logic clock = 1'b0, reset = 1'b1, key0_n = 1'b1, key1_n = 1'b1;
   logic o_inc_pulse, o_dec_pulse, o_key0_level, o_key1_level;
   int   errors = 0, checks = 0;

   key_pulse_gen #(
      .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(10),
      .REPEAT_PERIOD_CYCLES(5), .REPEAT_EN(1)
   ) dut (
      .clock(clock), .reset(reset), .i_key0_n(key0_n), .i_key1_n(key1_n),
      .o_inc_pulse(o_inc_pulse), .o_dec_pulse(o_dec_pulse),
      .o_key0_level(o_key0_level), .o_key1_level(o_key1_level)
   );

   always #5 clock = ~clock;

   task automatic step(input logic p0, input logic p1);
      key0_n = ~p0;
      key1_n = ~p1;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clock);
      #1;
      checks += 4;
      if (o_inc_pulse !== 1'b0) begin errors++; $display("FAIL reset_inc got %b expected 0", o_inc_pulse); end
      if (o_dec_pulse !== 1'b0) begin errors++; $display("FAIL reset_dec got %b expected 0", o_dec_pulse); end
      if (o_key0_level !== 1'b0) begin errors++; $display("FAIL reset_lvl0 got %b expected 0", o_key0_level); end
      if (o_key1_level !== 1'b0) begin errors++; $display("FAIL reset_lvl1 got %b expected 0", o_key1_level); end
      reset = 1'b0;
      for (int e = 0; e < 5; e++) begin
         step(1'b0, 1'b0);
         checks++;
         if ({o_inc_pulse, o_dec_pulse} !== 2'b00) begin
            errors++; $display("FAIL post_reset_pulse edge %0d got %b expected 00", e, {o_inc_pulse, o_dec_pulse});
         end
      end
   endtask

   task automatic test_clean_press;
      for (int e = 0; e < 20; e++) begin
         step(e < 8, 1'b0);
         checks += 3;
         if (o_inc_pulse !== (e == 7)) begin
            errors++; $display("FAIL clean_inc edge %0d got %b expected %b", e, o_inc_pulse, e == 7);
         end
         if (o_dec_pulse !== 1'b0) begin errors++; $display("FAIL clean_dec edge %0d got %b expected 0", e, o_dec_pulse); end
         if (o_key0_level !== (e >= 6 && e < 14)) begin
            errors++; $display("FAIL clean_lvl0 edge %0d got %b expected %b", e, o_key0_level, e >= 6 && e < 14);
         end
      end
      idle(10);
   endtask

   task automatic test_bounce;
      for (int e = 0; e < 16; e++) begin
         step(1'b0, e < 3 || (e >= 5 && e < 8));
         checks += 2;
         if (o_key1_level !== 1'b0) begin errors++; $display("FAIL bounce_lvl1 edge %0d got %b expected 0", e, o_key1_level); end
         if ({o_inc_pulse, o_dec_pulse} !== 2'b00) begin
            errors++; $display("FAIL bounce_pulse edge %0d got %b expected 00", e, {o_inc_pulse, o_dec_pulse});
         end
      end
      idle(10);
   endtask

   task automatic test_auto_repeat;
      int n = 0;
      logic exp;
      for (int e = 0; e < 40; e++) begin
         step(1'b1, 1'b0);
         exp = (e == 7 || e == 17 || e == 22 || e == 27 || e == 32 || e == 37);
         n += int'(o_inc_pulse === 1'b1);
         checks += 2;
         if (o_inc_pulse !== exp) begin errors++; $display("FAIL repeat_inc edge %0d got %b expected %b", e, o_inc_pulse, exp); end
         if (o_dec_pulse !== 1'b0) begin errors++; $display("FAIL repeat_dec edge %0d got %b expected 0", e, o_dec_pulse); end
      end
      checks++;
      if (n != 6) begin errors++; $display("FAIL repeat_count got %0d expected 6", n); end
      idle(30);
   endtask

   task automatic test_simultaneous;
      for (int e = 0; e < 20; e++) begin
         step(1'b1, 1'b1);
         checks += 2;
         if ({o_key0_level, o_key1_level} !== {2{e >= 6}}) begin
            errors++; $display("FAIL simul_lvls edge %0d got %b expected %b", e, {o_key0_level, o_key1_level}, {2{e >= 6}});
         end
         if ({o_inc_pulse, o_dec_pulse} !== 2'b00) begin
            errors++; $display("FAIL simul_pulse edge %0d got %b expected 00", e, {o_inc_pulse, o_dec_pulse});
         end
      end
      idle(20);
   endtask

   task automatic test_staggered;
      logic exp;
      for (int e = 0; e < 40; e++) begin
         step(e < 30, e >= 3 && e < 12);
         exp = (e == 7 || e == 22 || e == 27 || e == 32);
         checks += 3;
         if (o_inc_pulse !== exp) begin errors++; $display("FAIL stagger_inc edge %0d got %b expected %b", e, o_inc_pulse, exp); end
         if (o_dec_pulse !== 1'b0) begin errors++; $display("FAIL stagger_dec edge %0d got %b expected 0", e, o_dec_pulse); end
         if (o_key1_level !== (e >= 9 && e < 18)) begin
            errors++; $display("FAIL stagger_lvl1 edge %0d got %b expected %b", e, o_key1_level, e >= 9 && e < 18);
         end
      end
      idle(20);
   endtask

   task automatic test_reset_mid_hold;
      logic exp;
      for (int e = 0; e < 31; e++) begin
         if (e == 12) begin
            reset = 1'b1;
            #1;
            checks++;
            if ({o_inc_pulse, o_dec_pulse, o_key0_level, o_key1_level} !== 4'b0000) begin
               errors++; $display("FAIL rst_async got %b expected 0000", {o_inc_pulse, o_dec_pulse, o_key0_level, o_key1_level});
            end
         end
         if (e == 15) reset = 1'b0;
         step(1'b1, 1'b0);
         exp = (e == 7 || e == 22);
         checks += 2;
         if (o_inc_pulse !== exp) begin errors++; $display("FAIL rst_inc edge %0d got %b expected %b", e, o_inc_pulse, exp); end
         if (o_key0_level !== ((e >= 6 && e < 12) || e >= 21)) begin
            errors++; $display("FAIL rst_lvl0 edge %0d got %b expected %b", e, o_key0_level, (e >= 6 && e < 12) || e >= 21);
         end
      end
      idle(20);
   endtask

   initial begin
      test_reset;
      test_clean_press;
      test_bounce;
      test_auto_repeat;
      test_simultaneous;
      test_staggered;
      test_reset_mid_hold;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/key_pulse_gen.md
KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 125000, is the number of consecutive stable synchronized samples required to accept a key level change (1 ms at 125 MHz).
REQ-002 Parameter REPEAT_DELAY_CYCLES, default 62500000, is the hold time from the first pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD_CYCLES, default 12500000, is the interval between auto-repeat pulses after the first repeat.
REQ-004 Parameter REPEAT_EN, default 1, enables auto-repeat; 0 gives one pulse per press.
REQ-005 clock  input  1  single clock for all logic (125 MHz nominal).
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 i_key0_n  input  1  raw push-button "increase", active-low, asynchronous to clock, may bounce.
REQ-008 i_key1_n  input  1  raw push-button "decrease", active-low, asynchronous to clock, may bounce.
REQ-009 o_inc_pulse  output  1  one-cycle request to increase frequency step; feeds the DDS i_aumentar input.
REQ-010 o_dec_pulse  output  1  one-cycle request to decrease frequency step; feeds the DDS i_disminuir input.
REQ-011 o_key0_level  output  1  debounced key0 state, 1 = pressed.
REQ-012 o_key1_level  output  1  debounced key1 state, 1 = pressed.

Function
REQ-013 Each raw key SHALL pass through a 2-flop synchronizer, inverted to active-high, before any other logic.
REQ-014 Per key, a debounce counter SHALL increment while the synchronized value differs from the debounced level and clear to 0 when they match.
REQ-015 When the counter reaches DEBOUNCE_CYCLES-1 with the values still differing, the debounced level SHALL toggle on the next edge and the counter SHALL clear.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL NOT change the debounced level.
REQ-017 Counter widths SHALL be $clog2 of the respective parameter; counters SHALL saturate and never wrap.
REQ-018 Per key, a repeat FSM SHALL have the states IDLE, DELAY and REPEAT.
REQ-019 IDLE -> DELAY on the rising edge of the debounced level; one pulse SHALL be emitted in the cycle after the level rises.
REQ-020 In DELAY, the timer SHALL count REPEAT_DELAY_CYCLES; on expiry, one pulse SHALL be emitted and the FSM moves to REPEAT with the timer cleared.
REQ-021 In REPEAT, one pulse SHALL be emitted every REPEAT_PERIOD_CYCLES while the key is held.
REQ-022 With REPEAT_EN=0, the FSM SHALL stay in DELAY with the timer frozen and emit no further pulses.
REQ-023 A falling debounced level in any state SHALL return the FSM to IDLE in the next cycle, clear the timer, and emit no pulse.
REQ-024 Lockout: while both debounced levels are 1, both pulse outputs SHALL be 0.
REQ-025 Lockout: a press edge occurring while the other key is held SHALL NOT pulse, and its FSM SHALL still enter DELAY.
REQ-026 Lockout: repeat pulses SHALL resume only after the other key is released, on the next scheduled repeat.
REQ-027 Lockout: press edges on both keys in the same cycle SHALL produce no pulse.
REQ-028 o_inc_pulse and o_dec_pulse SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be registered.
REQ-030 Each pulse SHALL be exactly 1 cycle wide.

Reset
REQ-031 Reset assertion SHALL asynchronously force the synchronizers to "released", all counters and timers to 0, both FSMs to IDLE, and all four outputs to 0.
REQ-032 Reset mid-press SHALL abort any pending repeat pulse.
REQ-033 After reset release, a key already held SHALL be treated as a new press and pulse once after debouncing.
REQ-034 No pulse SHALL be generated during, or in the first 2 cycles after, reset deassertion.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=5, REPEAT_EN=1)
REQ-035 Clean press: i_key0_n low at edge 0 and held 8 cycles, then high -> o_key0_level=1 from edge 6, o_inc_pulse high only at edge 7, o_key0_level=0 at edge 14; no other pulses.
REQ-036 Bounce: i_key1_n low 3 cycles, high 2, low 3, high -> o_key1_level and o_dec_pulse stay 0 throughout.
REQ-037 Auto-repeat: key0 held 40 cycles -> o_inc_pulse at edges 7, 17, 22, 27, 32, 37 (one-cycle each); exactly 6 pulses.
REQ-038 Simultaneous press: both keys low at edge 0, held 20 cycles -> both levels 1 from edge 6, zero pulses on either output.
REQ-039 Staggered lockout: key0 pressed at 0, key1 pressed at 3, key1 released at 12 -> one o_inc_pulse at edge 7, no o_dec_pulse, and key0 repeats resume per its schedule once key1's level falls.
REQ-040 Reset mid-hold: key0 held, reset asserted at edge 12 for 3 cycles -> all outputs 0 immediately, the repeat at 17 is suppressed, and a new pulse occurs 7 cycles after reset release while the key stays held.
